btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
- Consumer end of the debounced button interface. Takes the debouncer's single debounced level (`btn_out`, high while any of N/E/S/W is held) plus the four raw button lines.
- Converts level changes into discrete press / auto-repeat / release events tagged with the button direction.
- Events are presented through a one-entry valid/ready buffer to the game controller.

Parameters:
- REPEAT_DELAY, 25000000, cycles from press event to first repeat (0.5 s @ 50 MHz); 0 disables auto-repeat.
- REPEAT_PERIOD, 5000000, cycles between successive repeats (0.1 s); must be >= 1.
- CNT_W, 25, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock, same domain as debouncer.
- rst_n  in  1  reset; asynchronous, active-low.
- btn_level  in  1  debounced level from debouncer (1 = some button held).
- btn_north, btn_east, btn_south, btn_west  in  1 each  raw button lines, sampled only at press.
- evt_valid  out  1  event buffer occupied.
- evt_ready  in  1  consumer accepts event when evt_valid & evt_ready.
- evt_kind  out  2  0 = PRESS, 1 = REPEAT, 2 = RELEASE (3 unused).
- evt_dir  out  2  0 = N, 1 = E, 2 = S, 3 = W.
- evt_multi  out  1  more than one raw line high at press.
- evt_drop  out  1  one-cycle pulse: PRESS/RELEASE overwrote an unaccepted event.
- held  out  1  level, 1 in HELD/REPEAT states.

Behaviour:
- Reset values: all outputs 0; state PRIME; counter 0; level_q 0.
- level_q registers btn_level each cycle. rise = btn_level & ~level_q; fall = ~btn_level & level_q.
- Event latency: an edge sampled at clock edge N gives evt_valid high after edge N (visible in cycle N+1).
- FSM states: PRIME, IDLE, HELD, REPEAT, SUPPRESS.
- PRIME: lasts exactly one cycle after reset release. Goes to SUPPRESS if btn_level = 1, else IDLE. Emits no event.
- IDLE: on rise, capture dir by priority N > E > S > W. evt_multi = (popcount of raw lines > 1). If no raw line is high, dir = N and multi = 0. Emit PRESS, clear counter, go to HELD.
- HELD: on fall, emit RELEASE with the latched dir/multi and go to IDLE. Else if REPEAT_DELAY != 0, increment counter; at counter == REPEAT_DELAY-1, emit REPEAT, clear counter, go to REPEAT.
- REPEAT: on fall, emit RELEASE and go to IDLE. Else at counter == REPEAT_PERIOD-1, emit REPEAT and clear counter.
- Fall has priority over a repeat expiring in the same cycle: only RELEASE is emitted.
- SUPPRESS: no events. On fall go to IDLE. Covers reset asserted while a button is held.
- held = 1 in HELD and REPEAT only.
- Buffer: load new event when buffer empty, or when evt_valid & evt_ready in the same cycle (no drop).
- Buffer occupied and not draining:
  - REPEAT is discarded silently.
  - PRESS/RELEASE overwrites kind/dir/multi and pulses evt_drop.
- Fields are stable while evt_valid = 1 and no overwrite occurs. evt_valid clears after the handshake when no new event arrives.
- rst_n asserted mid-operation: immediate clear of buffer, FSM and counter. A pending event is lost, with no evt_drop.
- Counter saturates at CNT_W all-ones; it never wraps into a false repeat.

Decomposition:
- Shared package btn_pkg:
  - EVT_PRESS/EVT_REPEAT/EVT_RELEASE kind constants.
  - DIR_N/E/S/W encodings.
  - FSM state encoding.
  - Default timing constants shared with the debouncer (10 ms settle, 50 MHz).
- One sub-module btn_evt_buf: the one-entry valid/ready buffer with overwrite/drop rules. The FSM and counter stay in btn_event_decoder.

Test Plan (REPEAT_DELAY=10, REPEAT_PERIOD=4, CNT_W=4):
- Reset with btn_level=0, then raise btn_level with btn_east=1 and evt_ready=1. Expect one PRESS, dir=1, multi=0, one cycle after the sampling edge. Drop after 5 cycles: expect RELEASE, dir=1, no REPEAT.
- Hold btn_level=1 with btn_west for 30 cycles, evt_ready=1. Expect REPEAT 10 cycles after PRESS, then every 4 cycles (4 repeats), then RELEASE on fall with dir=3.
- btn_north and btn_south both high at rise. Expect dir=0, multi=1. Fall in the same cycle the 10th hold cycle expires: expect RELEASE only.
- evt_ready=0 throughout press, repeats, release. Expect REPEATs dropped silently, RELEASE overwrites PRESS with evt_drop pulse, final buffer = RELEASE.
- Release rst_n while btn_level=1. Expect held=0 and no events until btn_level falls. Then a new press yields a normal PRESS.
- Assert rst_n low mid-REPEAT with evt_valid=1. Expect evt_valid=0, held=0, evt_drop=0 at once. Re-press yields PRESS after priming.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared encodings and default timing for the debounced button path.
// Used by the debouncer, the event decoder and its event buffer.
package btn_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_REPEAT  = 2'd1,
        EVT_RELEASE = 2'd2
    } evt_kind_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_PRIME    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_HELD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_SUPPRESS = 3'd4
    } state_t;

    localparam int unsigned CLK_HZ_C             = 32'd50_000_000;
    localparam int unsigned SETTLE_CYCLES_C      = CLK_HZ_C / 32'd100;
    localparam int unsigned REPEAT_DELAY_DEF_C   = CLK_HZ_C / 32'd2;
    localparam int unsigned REPEAT_PERIOD_DEF_C  = CLK_HZ_C / 32'd10;

    // Raw lines are packed {west, south, east, north}.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic dir_t prio_dir(input logic [3:0] v);
        dir_t d;
        if (v[0]) begin
            d = DIR_N;
        end else if (v[1]) begin
            d = DIR_E;
        end else if (v[2]) begin
            d = DIR_S;
        end else if (v[3]) begin
            d = DIR_W;
        end else begin
            d = DIR_N;
        end
        return d;
    endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// Valid/ready event channel from the button decoder to the game controller.
interface btn_event_decoder_if
    import btn_pkg::*;
    ();
    logic      evt_valid;
    logic      evt_ready;
    evt_kind_t evt_kind;
    dir_t      evt_dir;
    logic      evt_multi;
    logic      evt_drop;

    modport master (
        output evt_valid, evt_kind, evt_dir, evt_multi, evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_kind, evt_dir, evt_multi, evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/btn_evt_buf.sv
// One-entry event buffer: repeats yield to an occupied slot, press/release
// overwrite it and flag the lost event on evt_drop.
module btn_evt_buf
    import btn_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  evt_kind_t push_kind,
    input  dir_t      push_dir,
    input  logic      push_multi,
    btn_event_decoder_if.master evt
);

    logic      valid_r;
    evt_kind_t kind_r;
    dir_t      dir_r;
    logic      multi_r;
    logic      drop_r;
    logic      drain_s;
    logic      load_s;
    logic      ovw_s;

    // Decide between a clean load, an overwrite, or no change.
    always_comb begin
        drain_s = valid_r & evt.evt_ready;
        load_s  = 1'b0;
        ovw_s   = 1'b0;
        if (push && (!valid_r || drain_s)) begin
            load_s = 1'b1;
        end else if (push && (push_kind != EVT_REPEAT)) begin
            ovw_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Buffer storage and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            kind_r  <= EVT_PRESS;
            dir_r   <= DIR_N;
            multi_r <= 1'b0;
            drop_r  <= 1'b0;
        end else if (load_s || ovw_s) begin
            valid_r <= 1'b1;
            kind_r  <= push_kind;
            dir_r   <= push_dir;
            multi_r <= push_multi;
            drop_r  <= ovw_s;
        end else begin
            if (drain_s) begin
                valid_r <= 1'b0;
            end
            drop_r <= 1'b0;
        end
    end

    assign evt.evt_valid = valid_r;
    assign evt.evt_kind  = kind_r;
    assign evt.evt_dir   = dir_r;
    assign evt.evt_multi = multi_r;
    assign evt.evt_drop  = drop_r;

endmodule

// File: rtl/btn_event_decoder.sv
// Turns the debounced button level into press / auto-repeat / release events
// tagged with the direction sampled from the raw lines at press time.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF_C,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF_C,
    parameter int unsigned CNT_W         = 32'd25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    input  logic btn_north,
    input  logic btn_east,
    input  logic btn_south,
    input  logic btn_west,
    btn_event_decoder_if.master evt,
    output logic held
);

    localparam int unsigned DELAY_LAST_I  = (REPEAT_DELAY > 32'd0) ? REPEAT_DELAY - 32'd1 : 32'd0;
    localparam int unsigned PERIOD_LAST_I = (REPEAT_PERIOD > 32'd0) ? REPEAT_PERIOD - 32'd1 : 32'd0;
    localparam logic [CNT_W-1:0] DELAY_LAST_C  = DELAY_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] PERIOD_LAST_C = PERIOD_LAST_I[CNT_W-1:0];

    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             level_r;
    dir_t             dir_r, dir_n;
    logic             multi_r, multi_n;
    logic             held_r;
    logic [3:0]       raw_s;
    logic             rise_s, fall_s;
    logic             push_s;
    evt_kind_t        push_kind_s;

    // Saturating increment keeps a stuck counter from wrapping into a repeat.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign raw_s  = {btn_west, btn_south, btn_east, btn_north};
    assign rise_s = btn_level & ~level_r;
    assign fall_s = ~btn_level & level_r;

    // Next-state, counter and event generation.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        dir_n       = dir_r;
        multi_n     = multi_r;
        push_s      = 1'b0;
        push_kind_s = EVT_PRESS;
        case (state_r)
            ST_PRIME: begin
                state_n = btn_level ? ST_SUPPRESS : ST_IDLE;
            end
            ST_IDLE: begin
                if (rise_s) begin
                    dir_n       = prio_dir(raw_s);
                    multi_n     = (popcount4(raw_s) > 3'd1);
                    push_s      = 1'b1;
                    push_kind_s = EVT_PRESS;
                    cnt_n       = {CNT_W{1'b0}};
                    state_n     = ST_HELD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (fall_s) begin
                    push_s      = 1'b1;
                    push_kind_s = EVT_RELEASE;
                    state_n     = ST_IDLE;
                end else if (REPEAT_DELAY != 32'd0) begin
                    if (cnt_r == DELAY_LAST_C) begin
                        push_s      = 1'b1;
                        push_kind_s = EVT_REPEAT;
                        cnt_n       = {CNT_W{1'b0}};
                        state_n     = ST_REPEAT;
                    end else begin
                        cnt_n = sat_inc(cnt_r);
                    end
                end else begin
                    state_n = ST_HELD;
                end
            end
            ST_REPEAT: begin
                if (fall_s) begin
                    push_s      = 1'b1;
                    push_kind_s = EVT_RELEASE;
                    state_n     = ST_IDLE;
                end else if (cnt_r == PERIOD_LAST_C) begin
                    push_s      = 1'b1;
                    push_kind_s = EVT_REPEAT;
                    cnt_n       = {CNT_W{1'b0}};
                end else begin
                    cnt_n = sat_inc(cnt_r);
                end
            end
            ST_SUPPRESS: begin
                state_n = fall_s ? ST_IDLE : ST_SUPPRESS;
            end
            default: begin
                state_n = ST_PRIME;
            end
        endcase
    end

    // State, counter, latched direction and registered held flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_PRIME;
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            dir_r   <= DIR_N;
            multi_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            level_r <= btn_level;
            dir_r   <= dir_n;
            multi_r <= multi_n;
            held_r  <= (state_n == ST_HELD) || (state_n == ST_REPEAT);
        end
    end

    assign held = held_r;

    btn_evt_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_kind  (push_kind_s),
        .push_dir   (dir_n),
        .push_multi (multi_n),
        .evt        (evt)
    );

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with short repeat timing.
module tb_btn_event_decoder;

    logic clk;
    logic rst_n;
    logic btn_level;
    logic btn_north, btn_east, btn_south, btn_west;
    logic held;
    int   checks;
    int   errors;

    btn_event_decoder_if evt_if ();

    btn_event_decoder #(
        .REPEAT_DELAY  (32'd10),
        .REPEAT_PERIOD (32'd4),
        .CNT_W         (32'd4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_level (btn_level),
        .btn_north (btn_north),
        .btn_east  (btn_east),
        .btn_south (btn_south),
        .btn_west  (btn_west),
        .evt       (evt_if),
        .held      (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic [1:0] k, input logic [1:0] d,
                           input logic m, input logic dr, input logic h);
        chk({tag, ".valid"}, 32'(evt_if.evt_valid), 32'd1);
        chk({tag, ".kind"},  32'(evt_if.evt_kind),  32'(k));
        chk({tag, ".dir"},   32'(evt_if.evt_dir),   32'(d));
        chk({tag, ".multi"}, 32'(evt_if.evt_multi), 32'(m));
        chk({tag, ".drop"},  32'(evt_if.evt_drop),  32'(dr));
        chk({tag, ".held"},  32'(held),             32'(h));
    endtask

    task automatic chk_quiet(input string tag, input logic h);
        chk({tag, ".valid"}, 32'(evt_if.evt_valid), 32'd0);
        chk({tag, ".drop"},  32'(evt_if.evt_drop),  32'd0);
        chk({tag, ".held"},  32'(held),             32'(h));
    endtask

    task automatic set_raw(input logic n, input logic e, input logic s, input logic w);
        btn_north = n;
        btn_east  = e;
        btn_south = s;
        btn_west  = w;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        btn_level = 1'b0;
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        evt_if.evt_ready = 1'b1;

        // Reset state
        tick(2);
        chk_quiet("reset", 1'b0);
        chk("reset.kind", 32'(evt_if.evt_kind), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk_quiet("prime_idle", 1'b0);

        // Short east press, released before any repeat
        set_raw(1'b0, 1'b1, 1'b0, 1'b0);
        btn_level = 1'b1;
        tick(1);
        chk_evt("east_press", 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_quiet("east_drained", 1'b1);
        tick(3);
        chk_quiet("east_hold", 1'b1);
        btn_level = 1'b0;
        tick(1);
        chk_evt("east_release", 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_quiet("east_after", 1'b0);
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);

        // West held long: repeats at 10, 14, 18, 22 cycles after press
        set_raw(1'b0, 1'b0, 1'b0, 1'b1);
        btn_level = 1'b1;
        tick(1);
        chk_evt("west_press", 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 24; i++) begin
            tick(1);
            if (i == 10 || i == 14 || i == 18 || i == 22) begin
                chk_evt($sformatf("west_rep%0d", i), 2'd1, 2'd3, 1'b0, 1'b0, 1'b1);
            end else begin
                chk_quiet($sformatf("west_gap%0d", i), 1'b1);
            end
        end
        btn_level = 1'b0;
        tick(1);
        chk_evt("west_release", 2'd2, 2'd3, 1'b0, 1'b0, 1'b0);
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk_quiet("west_after", 1'b0);

        // North+south: multi; fall collides with first repeat expiry
        set_raw(1'b1, 1'b0, 1'b1, 1'b0);
        btn_level = 1'b1;
        tick(1);
        chk_evt("ns_press", 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        tick(9);
        chk_quiet("ns_hold", 1'b1);
        btn_level = 1'b0;
        tick(1);
        chk_evt("ns_release", 2'd2, 2'd0, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_quiet("ns_no_repeat", 1'b0);
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        tick(5);
        chk_quiet("ns_quiet", 1'b0);

        // Consumer stalled: repeats discarded, release overwrites press
        evt_if.evt_ready = 1'b0;
        set_raw(1'b0, 1'b0, 1'b1, 1'b0);
        btn_level = 1'b1;
        tick(1);
        chk_evt("stall_press", 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
        tick(19);
        chk_evt("stall_hold", 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
        btn_level = 1'b0;
        tick(1);
        chk_evt("stall_release", 2'd2, 2'd2, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_evt("stall_kept", 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        evt_if.evt_ready = 1'b1;
        tick(1);
        chk_quiet("stall_drained", 1'b0);
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset released while a button is held
        rst_n = 1'b0;
        set_raw(1'b0, 1'b1, 1'b0, 1'b0);
        btn_level = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        chk_quiet("suppress", 1'b0);
        btn_level = 1'b0;
        tick(1);
        chk_quiet("suppress_fall", 1'b0);
        tick(1);
        evt_if.evt_ready = 1'b0;
        btn_level = 1'b1;
        tick(1);
        chk_evt("post_suppress_press", 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);

        // Reset asserted mid-repeat with a pending event
        tick(12);
        chk_evt("pre_reset_pending", 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset", 1'b0);
        btn_level = 1'b0;
        set_raw(1'b0, 1'b0, 1'b0, 1'b1);
        tick(2);
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        tick(1);
        chk_quiet("reprime", 1'b0);
        btn_level = 1'b1;
        tick(1);
        chk_evt("repress", 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
